// File: rtl/sweep_sequencer.sv
// Frequency-sweep scheduler: walks the tuning-word table, loads the DDS, waits for
// settling, runs the detector handshake and writes one result entry per point.
module sweep_sequencer #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned SETTLE_WIDTH   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
   input  logic                    clk125,
   input  logic                    areset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_WIDTH-1:0]   num_points,
   input  logic [SETTLE_WIDTH-1:0] settle_cycles,
   output logic [ADDR_WIDTH-1:0]   rom_addr,
   input  logic [DATA_WIDTH-1:0]   rom_data,
   output logic [DATA_WIDTH-1:0]   ftw,
   output logic                    ftw_load,
   output logic                    det_start,
   input  logic                    det_done,
   output logic                    res_we,
   output logic [ADDR_WIDTH-1:0]   res_addr,
   output logic                    busy,
   output logic                    fin,
   output logic                    err
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_MEAS, S_STORE, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   np_q, np_d;
   logic [SETTLE_WIDTH-1:0] sc_q, sc_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [SETTLE_WIDTH-1:0] scnt_q, scnt_d;
   logic [TW-1:0]           tcnt_q, tcnt_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
   logic [DATA_WIDTH-1:0]   ftw_q, ftw_d;
   logic                    ftw_load_q, ftw_load_d;
   logic                    det_start_q, det_start_d;
   logic                    res_we_q, res_we_d;
   logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
   logic                    busy_q, busy_d;
   logic                    fin_q, fin_d;

   logic [SETTLE_WIDTH-1:0] settle_last;
   logic                    last_point;

   // A latched settle count of zero still spends one cycle in SETTLE.
   assign settle_last = (sc_q == '0) ? '0 : sc_q - SETTLE_WIDTH'(1);
   assign last_point  = (idx_q == np_q - ADDR_WIDTH'(1));

   always_ff @(posedge clk125 or posedge areset) begin
      if (areset) begin
         state_q     <= S_IDLE;
         np_q        <= '0;
         sc_q        <= '0;
         idx_q       <= '0;
         scnt_q      <= '0;
         tcnt_q      <= '0;
         err_q       <= 1'b0;
         rom_addr_q  <= '0;
         ftw_q       <= '0;
         ftw_load_q  <= 1'b0;
         det_start_q <= 1'b0;
         res_we_q    <= 1'b0;
         res_addr_q  <= '0;
         busy_q      <= 1'b0;
         fin_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         np_q        <= np_d;
         sc_q        <= sc_d;
         idx_q       <= idx_d;
         scnt_q      <= scnt_d;
         tcnt_q      <= tcnt_d;
         err_q       <= err_d;
         rom_addr_q  <= rom_addr_d;
         ftw_q       <= ftw_d;
         ftw_load_q  <= ftw_load_d;
         det_start_q <= det_start_d;
         res_we_q    <= res_we_d;
         res_addr_q  <= res_addr_d;
         busy_q      <= busy_d;
         fin_q       <= fin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      np_d    = np_q;
      sc_d    = sc_q;
      idx_d   = idx_q;
      scnt_d  = scnt_q;
      tcnt_d  = tcnt_q;
      err_d   = err_q;
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  np_d    = num_points;
                  sc_d    = settle_cycles;
                  idx_d   = '0;
                  err_d   = 1'b0;
                  state_d = (num_points == '0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
               scnt_d  = '0;
               state_d = S_SETTLE;
            end
            S_SETTLE: begin
               if (scnt_q == settle_last) begin
                  tcnt_d  = '0;
                  state_d = S_MEAS;
               end else begin
                  scnt_d = scnt_q + SETTLE_WIDTH'(1);
               end
            end
            S_MEAS: begin
               // det_done in the det_start cycle belongs to a stale request.
               if (tcnt_q != '0 && det_done) begin
                  state_d = S_STORE;
               end else if (tcnt_q == T_LAST) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            S_STORE: begin
               if (last_point) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + ADDR_WIDTH'(1);
                  state_d = S_FETCH;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so strobes coincide with their state.
   always_comb begin
      rom_addr_d  = (state_d == S_FETCH) ? idx_d : rom_addr_q;
      ftw_d       = (state_d == S_LOAD) ? rom_data : ftw_q;
      ftw_load_d  = (state_d == S_LOAD);
      det_start_d = (state_d == S_MEAS) && (state_q != S_MEAS);
      res_we_d    = (state_d == S_STORE);
      res_addr_d  = (state_d == S_STORE) ? idx_q : res_addr_q;
      busy_d      = (state_d != S_IDLE);
      fin_d       = (state_d == S_DONE);
   end

   assign rom_addr  = rom_addr_q;
   assign ftw       = ftw_q;
   assign ftw_load  = ftw_load_q;
   assign det_start = det_start_q;
   assign res_we    = res_we_q;
   assign res_addr  = res_addr_q;
   assign busy      = busy_q;
   assign fin       = fin_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: detector responder, event monitor and a cycle-count
// model of each sweep derived from the per-point schedule.
module tb_sweep_sequencer;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = 16;
   localparam int TO = 64;

   logic          clk125 = 1'b0;
   logic          areset;
   logic          start;
   logic          abort;
   logic [AW-1:0] num_points;
   logic [SW-1:0] settle_cycles;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] ftw;
   logic          ftw_load;
   logic          det_start;
   logic          det_done;
   logic          res_we;
   logic [AW-1:0] res_addr;
   logic          busy;
   logic          fin;
   logic          err;

   logic [DW-1:0] tbl [256];
   assign rom_data = tbl[rom_addr];

   sweep_sequencer #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .SETTLE_WIDTH  (SW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk125       (clk125),
      .areset       (areset),
      .start        (start),
      .abort        (abort),
      .num_points   (num_points),
      .settle_cycles(settle_cycles),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .ftw          (ftw),
      .ftw_load     (ftw_load),
      .det_start    (det_start),
      .det_done     (det_done),
      .res_we       (res_we),
      .res_addr     (res_addr),
      .busy         (busy),
      .fin          (fin),
      .err          (err)
   );

   always #4 clk125 = ~clk125;

   int cyc = 0;
   always @(posedge clk125) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // observed events
   logic [DW-1:0] q_ftw[$];
   int            q_ftw_c[$];
   int            q_ds_c[$];
   int            q_we_a[$];
   int            q_we_c[$];
   int            q_fin_c[$];
   // expected events
   logic [DW-1:0] e_ftw[$];
   int            e_ftw_c[$];
   int            e_ds_c[$];
   int            e_we_a[$];
   int            e_we_c[$];
   int            e_fin;

   int det_lat  = 1;
   bit det_echo = 1'b0;

   initial begin
      forever begin
         @(negedge clk125);
         if (ftw_load === 1'b1) begin q_ftw.push_back(ftw); q_ftw_c.push_back(cyc); end
         if (det_start === 1'b1) q_ds_c.push_back(cyc);
         if (res_we === 1'b1) begin q_we_a.push_back(int'(res_addr)); q_we_c.push_back(cyc); end
         if (fin === 1'b1) q_fin_c.push_back(cyc);
      end
   end

   // Detector: answers det_lat cycles after det_start, or only alongside it in echo mode.
   initial begin
      int pend;
      pend = 0;
      det_done = 1'b0;
      forever begin
         @(negedge clk125);
         det_done = 1'b0;
         if (areset === 1'b1) pend = 0;
         else if (det_start === 1'b1) begin
            if (det_echo) det_done = 1'b1;
            else pend = det_lat;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) det_done = 1'b1;
         end
      end
   end

   initial begin
      #(8 * 30000);
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   task automatic clear_q();
      q_ftw.delete(); q_ftw_c.delete(); q_ds_c.delete();
      q_we_a.delete(); q_we_c.delete(); q_fin_c.delete();
   endtask

   task automatic do_start(input int np, input int sc, output int t);
      @(negedge clk125);
      num_points    = AW'(np);
      settle_cycles = SW'(sc);
      start = 1'b1;
      t = cyc;
      @(negedge clk125);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output int ic, output bit ok);
      ok = 1'b0;
      ic = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk125);
         if (busy === 1'b0) begin ic = cyc; ok = 1'b1; break; end
      end
   endtask

   // Schedule model: each point costs FETCH+LOAD+settle+(latency+1 MEAS)+STORE.
   task automatic build_exp(input int np, input int sc, input int lat, input int t);
      int s, p;
      s = (sc == 0) ? 1 : sc;
      p = 4 + s + lat;
      e_ftw.delete(); e_ftw_c.delete(); e_ds_c.delete(); e_we_a.delete(); e_we_c.delete();
      for (int k = 0; k < np; k++) begin
         e_ftw.push_back(tbl[k]);
         e_ftw_c.push_back(t + 2 + k * p);
         e_ds_c.push_back(t + 3 + s + k * p);
         e_we_a.push_back(k);
         e_we_c.push_back(t + 4 + s + lat + k * p);
      end
      e_fin = t + 1 + np * p;
   endtask

   task automatic test_reset();
      logic [2*AW+DW+5:0] ov;
      repeat (3) @(negedge clk125);
      ov = {rom_addr, ftw, res_addr, ftw_load, det_start, res_we, busy, fin, err};
      checks++;
      if (ov !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0", ov);
      end
      areset = 1'b0;
   endtask

   task automatic test_reset_mid_sweep();
      int t, ic;
      bit ok;
      logic [2*AW+DW+5:0] ov;
      for (int k = 0; k < 4; k++) tbl[k] = $urandom | 32'h1;
      det_lat = 3;
      do_start(4, 20, t);
      while (cyc < t + 6) @(negedge clk125);
      #1 areset = 1'b1;
      #1 ov = {rom_addr, ftw, res_addr, ftw_load, det_start, res_we, busy, fin, err};
      checks++;
      if (ov !== '0) begin
         errors++;
         $display("FAIL reset_mid_sweep: got %h required 0", ov);
      end
      @(negedge clk125);
      areset = 1'b0;
      clear_q();
      det_lat = 2;
      do_start(2, 1, t);
      wait_idle(200, ic, ok);
      build_exp(2, 1, 2, t);
      checks++;
      if (!ok || q_we_a.size() != 2 || q_fin_c.size() != 1 || q_fin_c[0] != e_fin) begin
         errors++;
         $display("FAIL restart_after_reset: got %0d writes %0d fins idle_ok %0d required 2 writes fin at %0d",
                  q_we_a.size(), q_fin_c.size(), ok, e_fin);
      end
   endtask

   task automatic test_directed();
      int t, ic;
      bit ok;
      clear_q();
      tbl[0] = 32'h100; tbl[1] = 32'h200; tbl[2] = 32'h400;
      det_lat = 10;
      do_start(3, 5, t);
      wait_idle(300, ic, ok);
      build_exp(3, 5, 10, t);
      checks++;
      if (q_ds_c.size() == 0 || q_ds_c[0] != t + 8) begin
         errors++;
         $display("FAIL first_det_start: got %0d required %0d", (q_ds_c.size() > 0) ? q_ds_c[0] - t : -1, 8);
      end
      checks++;
      if (q_ftw.size() != 3) begin
         errors++;
         $display("FAIL dir_ftw_count: got %0d required 3", q_ftw.size());
      end else for (int i = 0; i < 3; i++) begin
         checks++;
         if (q_ftw[i] !== e_ftw[i] || q_ftw_c[i] != e_ftw_c[i]) begin
            errors++;
            $display("FAIL dir_ftw[%0d]: got %h@%0d required %h@%0d", i, q_ftw[i], q_ftw_c[i], e_ftw[i], e_ftw_c[i]);
         end
      end
      checks++;
      if (q_we_a.size() != 3) begin
         errors++;
         $display("FAIL dir_we_count: got %0d required 3", q_we_a.size());
      end else for (int i = 0; i < 3; i++) begin
         checks++;
         if (q_we_a[i] != e_we_a[i] || q_we_c[i] != e_we_c[i]) begin
            errors++;
            $display("FAIL dir_we[%0d]: got %0d@%0d required %0d@%0d", i, q_we_a[i], q_we_c[i], e_we_a[i], e_we_c[i]);
         end
      end
      checks++;
      if (!ok || q_fin_c.size() != 1 || q_fin_c[0] != e_fin || ic != e_fin + 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL dir_fin: got %0d fins idle@%0d err %b required 1 fin@%0d idle@%0d err 0",
                  q_fin_c.size(), ic, err, e_fin, e_fin + 1);
      end
   endtask

   task automatic test_empty();
      int t, ic;
      bit ok;
      clear_q();
      do_start(0, 4, t);
      wait_idle(20, ic, ok);
      checks++;
      if (q_ftw.size() + q_ds_c.size() + q_we_a.size() != 0) begin
         errors++;
         $display("FAIL empty_activity: got %0d events required 0", q_ftw.size() + q_ds_c.size() + q_we_a.size());
      end
      checks++;
      if (q_fin_c.size() != 1 || q_fin_c[0] != t + 1 || ic != t + 2) begin
         errors++;
         $display("FAIL empty_fin: got %0d fins first@%0d idle@%0d required 1 fin@%0d idle@%0d",
                  q_fin_c.size(), (q_fin_c.size() > 0) ? q_fin_c[0] : -1, ic, t + 1, t + 2);
      end
   endtask

   task automatic test_timeout();
      int t, ic;
      bit ok;
      clear_q();
      det_echo = 1'b1;
      do_start(2, 3, t);
      wait_idle(200, ic, ok);
      det_echo = 1'b0;
      checks++;
      if (q_ftw.size() != 1 || q_ds_c.size() != 1 || q_we_a.size() != 0) begin
         errors++;
         $display("FAIL timeout_activity: got ftw %0d ds %0d we %0d required 1 1 0",
                  q_ftw.size(), q_ds_c.size(), q_we_a.size());
      end
      checks++;
      if (!ok || q_fin_c.size() != 1 || q_fin_c[0] != t + 6 + TO || err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_fin_err: got fin@%0d err %b required fin@%0d err 1",
                  (q_fin_c.size() > 0) ? q_fin_c[0] : -1, err, t + 6 + TO);
      end
      clear_q();
      det_lat = 2;
      do_start(1, 0, t);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got %b required 0", err);
      end
      wait_idle(100, ic, ok);
      checks++;
      if (!ok || q_we_a.size() != 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL after_timeout_sweep: got %0d writes err %b required 1 write err 0", q_we_a.size(), err);
      end
   endtask

   task automatic test_abort();
      int t, ic, s, lat, a;
      bit ok;
      clear_q();
      s = $urandom_range(0, 4);
      lat = $urandom_range(2, 6);
      for (int k = 0; k < 3; k++) tbl[k] = $urandom;
      det_lat = lat;
      do_start(3, s, t);
      build_exp(3, s, lat, t);
      a = e_ds_c[1] + lat;
      while (cyc < a) @(negedge clk125);
      abort = 1'b1;
      @(negedge clk125);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || res_we !== 1'b0) begin
         errors++;
         $display("FAIL abort_next_cycle: got busy %b res_we %b required 0 0", busy, res_we);
      end
      repeat (10) @(negedge clk125);
      checks++;
      if (q_we_a.size() != 1 || q_fin_c.size() != 0 || q_ds_c.size() != 2 || q_ftw.size() != 2) begin
         errors++;
         $display("FAIL abort_activity: got we %0d fin %0d ds %0d ftw %0d required 1 0 2 2",
                  q_we_a.size(), q_fin_c.size(), q_ds_c.size(), q_ftw.size());
      end
      checks++;
      if (ftw !== tbl[1]) begin
         errors++;
         $display("FAIL abort_ftw_hold: got %h required %h", ftw, tbl[1]);
      end
   endtask

   task automatic test_random_restart();
      int t, ic, np, sc, lat, s;
      bit ok;
      for (int it = 0; it < 8; it++) begin
         clear_q();
         np  = $urandom_range(1, 6);
         sc  = $urandom_range(0, 6);
         lat = $urandom_range(1, 8);
         s   = (sc == 0) ? 1 : sc;
         for (int k = 0; k < np; k++) tbl[k] = $urandom;
         det_lat = lat;
         do_start(np, sc, t);
         if (it % 2 == 1) begin
            while (cyc < t + 4 + s) @(negedge clk125);
            settle_cycles = SW'(sc + 7);
            start = 1'b1;
            @(negedge clk125);
            start = 1'b0;
         end
         wait_idle(400, ic, ok);
         build_exp(np, sc, lat, t);
         checks++;
         if (q_ftw.size() != np || q_ds_c.size() != np || q_we_a.size() != np) begin
            errors++;
            $display("FAIL rnd%0d_counts: got ftw %0d ds %0d we %0d required %0d each",
                     it, q_ftw.size(), q_ds_c.size(), q_we_a.size(), np);
         end else for (int i = 0; i < np; i++) begin
            checks++;
            if (q_ftw[i] !== e_ftw[i] || q_ftw_c[i] != e_ftw_c[i] || q_ds_c[i] != e_ds_c[i] ||
                q_we_a[i] != e_we_a[i] || q_we_c[i] != e_we_c[i]) begin
               errors++;
               $display("FAIL rnd%0d_pt%0d: got ftw %h@%0d ds@%0d we %0d@%0d required ftw %h@%0d ds@%0d we %0d@%0d",
                        it, i, q_ftw[i], q_ftw_c[i], q_ds_c[i], q_we_a[i], q_we_c[i],
                        e_ftw[i], e_ftw_c[i], e_ds_c[i], e_we_a[i], e_we_c[i]);
            end
         end
         checks++;
         if (!ok || q_fin_c.size() != 1 || q_fin_c[0] != e_fin || ic != e_fin + 1) begin
            errors++;
            $display("FAIL rnd%0d_fin: got %0d fins idle@%0d required fin@%0d idle@%0d",
                     it, q_fin_c.size(), ic, e_fin, e_fin + 1);
         end
      end
   endtask

   initial begin
      areset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      num_points = '0;
      settle_cycles = '0;
      for (int i = 0; i < 256; i++) tbl[i] = 32'h0;
      test_reset();
      test_reset_mid_sweep();
      test_directed();
      test_empty();
      test_timeout();
      test_abort();
      test_random_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
